perceptron_scheduler: RTL and testbench

//   Shares one combinational perceptron classifier between NUM_REQ requesters.

---
 rtl/perceptron_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_perceptron_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_scheduler.sv
// -----------------------------------------------------------------------------
// perceptron_scheduler
//   This block lets NUM_REQ feature-extraction front ends share one
//   combinational perceptron classifier.
//   A round-robin arbiter accepts one {edges, curves} sample at a time and
//   drives it onto the perceptron operand outputs. It holds the sample for
//   SETTLE_CYCLES cycles, captures the class, and then offers the class with
//   the requester id on a valid/ready result port.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   req_valid[NUM_REQ]     per-requester sample valid
//   req_ready[NUM_REQ]     one-hot grant, asserted only in IDLE
//   req_edges/req_curves   packed samples, slot i at [3i+2:3i] / [4i+3:4i]
//   pc_edges/pc_curves     registered operands to the shared perceptron
//   pc_out                 perceptron class output
//   res_valid/res_ready    result handshake
//   res_class/res_id       captured class and owning requester
//   res_oor                captured class above 9 (no class matched)
//   busy                   scheduler not idle
//
// Optional feature macro: SCHED_STATS_EN
//   When defined, stat_done[15:0] and stat_oor[15:0] count handed-off results.
//   stat_oor counts only results with res_oor set. Both counters saturate.
// -----------------------------------------------------------------------------
module perceptron_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*3-1:0] req_edges,
    input  logic [NUM_REQ*4-1:0] req_curves,
    output logic [2:0]           pc_edges,
    output logic [3:0]           pc_curves,
    input  logic [3:0]           pc_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_class,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_oor,
    output logic                 busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]          stat_done,
    output logic [15:0]          stat_oor
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Any code above 9 means no class matched
    function automatic logic class_oor(input logic [3:0] c);
        return (c > 4'd9);
    endfunction

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [3:0]          r_cnt;
    logic [2:0]          r_op_edges;
    logic [3:0]          r_op_curves;
    logic                r_res_valid;
    logic [3:0]          r_res_class;
    logic [ID_W-1:0]     r_res_id;
    logic                r_res_oor;
    logic                r_busy;

    logic [2:0]          w_e [NUM_REQ];
    logic [3:0]          w_c [NUM_REQ];
    logic                w_found;
    logic [ID_W-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0]  w_gnt_onehot;

    // Unpack the flat sample buses into per-requester slots
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_e[g] = req_edges[3*g+2:3*g];
        assign w_c[g] = req_curves[4*g+3:4*g];
    end

    // Round-robin search. The first loop covers indices above the pointer and
    // the second wraps around to 0..ptr, so the last winner has lowest priority.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = {ID_W{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j > int'(r_ptr)) && req_valid[ID_W'(j)]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'(j);
            end else begin
                w_found   = w_found;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j <= int'(r_ptr)) && req_valid[ID_W'(j)]) begin
                w_found   = 1'b1;
                w_gnt_idx = ID_W'(j);
            end else begin
                w_found   = w_found;
            end
        end
    end

    // Grant pulse. It is suppressed during reset so that no handshake appears
    // to complete while the FSM is being cleared.
    always_comb begin
        w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
        if ((r_state == ST_IDLE) && w_found && !rst) begin
            req_ready = w_gnt_onehot;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Scheduler FSM: accept, settle, capture, hand off
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_cnt       <= 4'd0;
            r_op_edges  <= 3'd0;
            r_op_curves <= 4'd0;
            r_res_valid <= 1'b0;
            r_res_class <= 4'd0;
            r_res_id    <= {ID_W{1'b0}};
            r_res_oor   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_op_edges  <= w_e[w_gnt_idx];
                        r_op_curves <= w_c[w_gnt_idx];
                        r_res_id    <= w_gnt_idx;
                        r_ptr       <= w_gnt_idx;
                        r_cnt       <= 4'(SETTLE_CYCLES);
                        r_busy      <= 1'b1;
                        r_state     <= ST_SETTLE;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    // The capture happens on the last settle cycle, so any
                    // earlier pc_out glitches are ignored.
                    if (r_cnt == 4'd1) begin
                        r_res_class <= pc_out;
                        r_res_oor   <= class_oor(pc_out);
                        r_res_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt       <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_edges  = r_op_edges;
    assign pc_curves = r_op_curves;
    assign res_valid = r_res_valid;
    assign res_class = r_res_class;
    assign res_id    = r_res_id;
    assign res_oor   = r_res_oor;
    assign busy      = r_busy;

`ifdef SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic        w_res_hs;
    logic [15:0] r_stat_done;
    logic [15:0] r_stat_oor;

    assign w_res_hs = r_res_valid && res_ready && (r_state == ST_RESP);

    // Saturating hand-off counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_done <= 16'd0;
            r_stat_oor  <= 16'd0;
        end else if (w_res_hs) begin
            r_stat_done <= sat_inc(r_stat_done);
            if (r_res_oor) begin
                r_stat_oor <= sat_inc(r_stat_oor);
            end
        end
    end

    assign stat_done = r_stat_done;
    assign stat_oor  = r_stat_oor;
`endif

endmodule

// File: tb/tb_perceptron_scheduler.sv
module tb_perceptron_scheduler;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance, SETTLE_CYCLES = 1
    logic [3:0]  req_valid, req_ready;
    logic [11:0] req_edges;
    logic [15:0] req_curves;
    logic [2:0]  pc_edges;
    logic [3:0]  pc_curves, pc_out;
    logic        res_valid, res_ready, res_oor, busy;
    logic [3:0]  res_class;
    logic [1:0]  res_id;
    logic        pc_ovr_en;
    logic [3:0]  pc_ovr_val;

    // Second instance, SETTLE_CYCLES = 3
    logic [3:0]  req_valid3, req_ready3;
    logic [11:0] req_edges3;
    logic [15:0] req_curves3;
    logic [2:0]  pc_edges3;
    logic [3:0]  pc_curves3, pc_out3;
    logic        res_valid3, res_ready3, res_oor3, busy3;
    logic [3:0]  res_class3;
    logic [1:0]  res_id3;

`ifdef SCHED_STATS_EN
    logic [15:0] stat_done, stat_oor, stat_done3, stat_oor3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference perceptron: class = edges + curves, wrapping modulo 16
    function automatic logic [3:0] model(input logic [2:0] e, input logic [3:0] c);
        return ({1'b0, e} + c);
    endfunction

    assign pc_out = pc_ovr_en ? pc_ovr_val : model(pc_edges, pc_curves);

    perceptron_scheduler #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_edges(req_edges), .req_curves(req_curves),
        .pc_edges(pc_edges), .pc_curves(pc_curves), .pc_out(pc_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_id(res_id), .res_oor(res_oor),
        .busy(busy)
`ifdef SCHED_STATS_EN
        , .stat_done(stat_done), .stat_oor(stat_oor)
`endif
    );

    perceptron_scheduler #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_edges(req_edges3), .req_curves(req_curves3),
        .pc_edges(pc_edges3), .pc_curves(pc_curves3), .pc_out(pc_out3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_class(res_class3), .res_id(res_id3), .res_oor(res_oor3),
        .busy(busy3)
`ifdef SCHED_STATS_EN
        , .stat_done(stat_done3), .stat_oor(stat_oor3)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] edges;
        logic [15:0] curves;
        logic [1:0]  id;
        logic [3:0]  cls;
        logic        oor;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    // One complete transaction from IDLE on the SETTLE_CYCLES=1 instance
    task automatic do_txn(input string nm, input vec_t v);
        logic [3:0] oh;
        logic [2:0] e_exp;
        logic [3:0] c_exp;
        oh    = 4'b0001 << v.id;
        e_exp = v.edges[int'(v.id)*3 +: 3];
        c_exp = v.curves[int'(v.id)*4 +: 4];
        req_valid  = v.valid;
        req_edges  = v.edges;
        req_curves = v.curves;
        res_ready  = 1'b1;
        #1;
        chk({nm, ".grant"}, {28'd0, req_ready}, {28'd0, oh});
        step();
        req_valid = 4'b0000;
        #1;
        chk({nm, ".ready_settle"}, {28'd0, req_ready}, 32'd0);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd1);
        chk({nm, ".pc_edges"}, {29'd0, pc_edges}, {29'd0, e_exp});
        chk({nm, ".pc_curves"}, {28'd0, pc_curves}, {28'd0, c_exp});
        chk({nm, ".no_early_valid"}, {31'd0, res_valid}, 32'd0);
        step();
        chk({nm, ".res_valid"}, {31'd0, res_valid}, 32'd1);
        chk({nm, ".res_id"}, {30'd0, res_id}, {30'd0, v.id});
        chk({nm, ".res_class"}, {28'd0, res_class}, {28'd0, v.cls});
        chk({nm, ".res_oor"}, {31'd0, res_oor}, {31'd0, v.oor});
        step();
        chk({nm, ".valid_drop"}, {31'd0, res_valid}, 32'd0);
        chk({nm, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int g;
        int last;
        vecs[0] = '{4'b0001, 12'h004, 16'h0000, 2'd0, 4'd4,  1'b0};
        vecs[1] = '{4'b1111, 12'h8D1, 16'h9876, 2'd1, 4'd9,  1'b0};
        vecs[2] = '{4'b1001, 12'h8D1, 16'h9876, 2'd3, 4'd13, 1'b1};
        vecs[3] = '{4'b0110, 12'h8D1, 16'h0000, 2'd1, 4'd2,  1'b0};
        vecs[4] = '{4'b0001, 12'h007, 16'h0003, 2'd0, 4'd10, 1'b1};
        vecs[5] = '{4'b1000, 12'hE00, 16'hF000, 2'd3, 4'd6,  1'b0};
        vecs[6] = '{4'b0100, 12'h140, 16'h0900, 2'd2, 4'd14, 1'b1};

        rst = 1'b1;
        req_valid = 4'hF; req_edges = 12'hFFF; req_curves = 16'hFFFF; res_ready = 1'b0;
        pc_ovr_en = 1'b0; pc_ovr_val = 4'd0;
        req_valid3 = 4'h0; req_edges3 = 12'h000; req_curves3 = 16'h0000;
        res_ready3 = 1'b0; pc_out3 = 4'd0;
        step();
        step();
        // Reset state, checked with requests pending
        chk("rst.req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst.res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.pc_edges", {29'd0, pc_edges}, 32'd0);
        chk("rst.pc_curves", {28'd0, pc_curves}, 32'd0);
        chk("rst.res_class", {28'd0, res_class}, 32'd0);
        chk("rst.res_id", {30'd0, res_id}, 32'd0);
        chk("rst.res_oor", {31'd0, res_oor}, 32'd0);
        rst = 1'b0;
        req_valid = 4'h0;
        step();

        // Table-driven transactions; expected ids follow the rotating pointer
        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // All four requesters valid: grants 0,1,2,3,0,1, three cycles apart
        rst = 1'b1; step(); rst = 1'b0;
        req_valid = 4'hF; req_edges = 12'h8D1; req_curves = 16'h9876; res_ready = 1'b1;
        #1;
        g = 0; last = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            chk("rr.onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (req_ready != 4'b0000) begin
                chk($sformatf("rr.order%0d", g), {28'd0, req_ready}, 32'(4'b0001 << (g % 4)));
                if (g > 0) begin
                    chk("rr.gap", 32'(cyc - last), 32'd3);
                end
                last = cyc;
                g++;
            end
            step();
        end
        chk("rr.count", 32'(g), 32'd6);
        req_valid = 4'h0;
        wait_idle("rr.drain");

        // Back-pressure: result held while res_ready is low, no grants
        req_valid = 4'b0100; req_edges = 12'h0C0; req_curves = 16'h0400; res_ready = 1'b0;
        #1;
        chk("bp.grant", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b1011;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("bp.valid", {31'd0, res_valid}, 32'd1);
            chk("bp.class", {28'd0, res_class}, 32'd7);
            chk("bp.id", {30'd0, res_id}, 32'd2);
            chk("bp.no_grant", {28'd0, req_ready}, 32'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        chk("bp.hs_no_grant", {28'd0, req_ready}, 32'd0);
        step();
        chk("bp.valid_drop", {31'd0, res_valid}, 32'd0);
        chk("bp.idle", {31'd0, busy}, 32'd0);
        chk("bp.next_grant", {28'd0, req_ready}, 32'h8);
        step();
        req_valid = 4'h0;
        wait_idle("bp.drain");

        // Out-of-range class from the perceptron
        rst = 1'b1; step(); rst = 1'b0;
`ifdef SCHED_STATS_EN
        chk("stat.clr_done", {16'd0, stat_done}, 32'd0);
        chk("stat.clr_oor", {16'd0, stat_oor}, 32'd0);
`endif
        pc_ovr_en = 1'b1; pc_ovr_val = 4'd12;
        do_txn("oor", '{4'b0001, 12'h003, 16'h0002, 2'd0, 4'd12, 1'b1});
        pc_ovr_en = 1'b0;
`ifdef SCHED_STATS_EN
        chk("stat.done", {16'd0, stat_done}, 32'd1);
        chk("stat.oor", {16'd0, stat_oor}, 32'd1);
`endif

        // Reset while in SETTLE: in-flight sample discarded, pointer restored
        req_valid = 4'b0001; req_edges = 12'h005; req_curves = 16'h0006;
        #1;
        chk("rs.grant", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs.busy", {31'd0, busy}, 32'd0);
        chk("rs.res_valid", {31'd0, res_valid}, 32'd0);
        chk("rs.pc_edges", {29'd0, pc_edges}, 32'd0);
        chk("rs.pc_curves", {28'd0, pc_curves}, 32'd0);
        chk("rs.res_class", {28'd0, res_class}, 32'd0);
        chk("rs.res_oor", {31'd0, res_oor}, 32'd0);
        step();
        chk("rs.no_stale", {31'd0, res_valid}, 32'd0);
        req_valid = 4'hF;
        #1;
        chk("rs.first_grant", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'h0;
        wait_idle("rs.drain");

        // SETTLE_CYCLES=3: only the last settle-cycle pc_out is captured
        req_valid3 = 4'b0010; req_edges3 = 12'h030; req_curves3 = 16'h0010; pc_out3 = 4'd5;
        #1;
        chk("s3.grant", {28'd0, req_ready3}, 32'h2);
        step();
        req_valid3 = 4'h0;
        chk("s3.pc_edges", {29'd0, pc_edges3}, 32'd6);
        chk("s3.wait1", {31'd0, res_valid3}, 32'd0);
        step();
        pc_out3 = 4'd7;
        chk("s3.wait2", {31'd0, res_valid3}, 32'd0);
        step();
        pc_out3 = 4'd11;
        chk("s3.wait3", {31'd0, res_valid3}, 32'd0);
        step();
        pc_out3 = 4'd3;
        chk("s3.valid", {31'd0, res_valid3}, 32'd1);
        chk("s3.class", {28'd0, res_class3}, 32'd11);
        chk("s3.oor", {31'd0, res_oor3}, 32'd1);
        chk("s3.id", {30'd0, res_id3}, 32'd1);
        res_ready3 = 1'b1;
        step();
        chk("s3.valid_drop", {31'd0, res_valid3}, 32'd0);
        chk("s3.idle", {31'd0, busy3}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
